// File: rtl/sda_to_par.sv
// Serial-to-parallel receiver: decodes start/bit/stop framing on scl/sda into a DW-bit
// payload, with a one-hot decode, a commit strobe and an abort strobe.
module sda_to_par #(
  parameter int DW = 4,
  parameter int OW = 2**DW
) (
  input  logic          sclk,
  input  logic          rst,
  input  logic          scl,
  input  logic          sda,
  output logic [DW-1:0] data,
  output logic [OW-1:0] outhigh,
  output logic          rdy,
  output logic          frm_err
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, BIT, WAIT_STOP} state_t;

  state_t        state, state_nxt;
  logic          scl_q, scl_d, sda_q, sda_d;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [DW-1:0] shift, shift_nxt, data_nxt;
  logic [OW-1:0] outhigh_nxt;
  logic          rdy_nxt, frm_err_nxt;
  logic          start_c, stop_c, strobe;

  function automatic logic [OW-1:0] onehot(input logic [DW-1:0] v);
    logic [OW-1:0] r;
    r    = '0;
    r[v] = 1'b1;
    return r;
  endfunction

  // Sample stage: reset to an idle-high bus so leaving reset looks like no edge at all
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      scl_q <= 1'b1;
      scl_d <= 1'b1;
      sda_q <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_q <= scl;
      scl_d <= scl_q;
      sda_q <= sda;
      sda_d <= sda_q;
    end
  end

  assign start_c = scl_d & scl_q &  sda_d & ~sda_q;
  assign stop_c  = scl_d & scl_q & ~sda_d &  sda_q;
  assign strobe  = ~scl_d & scl_q;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shift_nxt   = shift;
    data_nxt    = data;
    outhigh_nxt = outhigh;
    rdy_nxt     = 1'b0;
    frm_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start_c) begin
          state_nxt = BIT;
          cnt_nxt   = CW'(DW - 1);
          shift_nxt = '0;
        end
      end
      BIT: begin
        if (start_c) begin
          cnt_nxt   = CW'(DW - 1);
          shift_nxt = '0;
        end else if (stop_c) begin
          frm_err_nxt = 1'b1;
          state_nxt   = IDLE;
        end else if (strobe) begin
          shift_nxt = (shift << 1) | DW'(sda_q);
          if (cnt == '0) state_nxt = WAIT_STOP;
          else           cnt_nxt   = cnt - CW'(1);
        end
      end
      WAIT_STOP: begin
        // Extra clocks after the last payload bit are ignored until stop or restart
        if (start_c) begin
          state_nxt = BIT;
          cnt_nxt   = CW'(DW - 1);
          shift_nxt = '0;
        end else if (stop_c) begin
          data_nxt    = shift;
          outhigh_nxt = onehot(shift);
          rdy_nxt     = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame stage: outputs registered so commit lands one edge after stop is sampled
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shift   <= '0;
      data    <= '0;
      outhigh <= '0;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      shift   <= shift_nxt;
      data    <= data_nxt;
      outhigh <= outhigh_nxt;
      rdy     <= rdy_nxt;
      frm_err <= frm_err_nxt;
    end
  end

endmodule

// File: tb/tb_sda_to_par.sv
// Bench for sda_to_par: directed frames plus random frame/abort/restart/reset traffic,
// checked against a transaction-level frame model.
module tb_sda_to_par;

  localparam int DW = 4;
  localparam int OW = 16;

  logic          sclk = 1'b0;
  logic          rst  = 1'b0;
  logic          scl  = 1'b1;
  logic          sda  = 1'b1;
  logic [DW-1:0] data;
  logic [OW-1:0] outhigh;
  logic          rdy, frm_err;

  sda_to_par #(.DW(DW), .OW(OW)) dut (
    .sclk(sclk), .rst(rst), .scl(scl), .sda(sda),
    .data(data), .outhigh(outhigh), .rdy(rdy), .frm_err(frm_err)
  );

  always #5 sclk = ~sclk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse counters
  int rdy_seen = 0, err_seen = 0, both_seen = 0;
  always @(negedge sclk) begin
    if (rdy === 1'b1) rdy_seen++;
    if (frm_err === 1'b1) err_seen++;
    if (rdy === 1'b1 && frm_err === 1'b1) both_seen++;
  end

  // Frame model: tracks bits clocked since the last start
  bit            in_frame = 0;
  int            nbits    = 0;
  int            val      = 0;
  logic [DW-1:0] exp_data = '0;
  logic [OW-1:0] exp_oh   = '0;
  int            commits  = 0;
  int            errs     = 0;

  task automatic m_start();
    in_frame = 1; nbits = 0; val = 0;
  endtask

  task automatic m_strobe(input bit b);
    if (in_frame && nbits < DW) begin
      val = val * 2 + int'(b);
      nbits++;
    end
  endtask

  task automatic m_stop(output bit r, output bit e);
    r = 0; e = 0;
    if (in_frame) begin
      if (nbits == DW) begin
        exp_data = val[DW-1:0];
        exp_oh   = OW'(1) << val;
        r = 1; commits++;
      end else begin
        e = 1; errs++;
      end
    end
    in_frame = 0;
  endtask

  task automatic put(input logic c, input logic d);
    @(posedge sclk); #1;
    scl = c; sda = d;
  endtask

  task automatic send_bit(input logic b);
    put(1'b0, sda);
    put(1'b0, b);
    put(1'b1, b);
    m_strobe(b);
  endtask

  task automatic send_start();
    if (sda == 1'b0) begin
      put(1'b0, 1'b0);
      put(1'b0, 1'b1);
      put(1'b1, 1'b1);
      m_strobe(1'b1);
    end
    put(1'b1, 1'b0);
    m_start();
  endtask

  task automatic send_stop();
    bit r, e;
    if (sda == 1'b1) begin
      put(1'b0, 1'b1);
      put(1'b0, 1'b0);
      put(1'b1, 1'b0);
      m_strobe(1'b0);
    end
    put(1'b1, 1'b1);
    m_stop(r, e);
    @(posedge sclk); @(posedge sclk); #1;
    check_val("rdy_pulse", rdy, r);
    check_val("err_pulse", frm_err, e);
    check_val("data", data, exp_data);
    check_val("outhigh", outhigh, exp_oh);
    @(posedge sclk); #1;
    check_val("rdy_one_cycle", rdy, 1'b0);
    check_val("err_one_cycle", frm_err, 1'b0);
  endtask

  task automatic send_frame(input logic [DW-1:0] v);
    send_start();
    for (int i = DW - 1; i >= 0; i--) send_bit(v[i]);
    send_stop();
  endtask

  task automatic do_reset();
    @(posedge sclk); #1;
    rst = 1'b0; scl = 1'b1; sda = 1'b1;
    in_frame = 0; exp_data = '0; exp_oh = '0;
    repeat (2) @(posedge sclk);
    #1;
    check_val("rst_data", data, '0);
    check_val("rst_outhigh", outhigh, '0);
    check_val("rst_rdy", rdy, 1'b0);
    check_val("rst_err", frm_err, 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0;
    do_reset();
    repeat (20) @(posedge sclk);
    #1;
    check_val("idle_data", data, '0);
    check_val("idle_outhigh", outhigh, '0);
    check_val("idle_rdy_cnt", rdy_seen, 0);
    check_val("idle_err_cnt", err_seen, 0);

    send_frame(4'hB);
    check_val("frame_B_data", data, 4'hB);
    check_val("frame_B_oh", outhigh, 16'h0800);

    send_frame(4'h0);
    check_val("frame_0_oh", outhigh, 16'h0001);
    send_frame(4'hF);
    check_val("frame_F_oh", outhigh, 16'h8000);
    check_val("rdy_cnt_3", rdy_seen, 3);

    send_start(); send_bit(1'b1); send_bit(1'b1); send_stop();
    check_val("short_keep_data", data, 4'hF);
    check_val("short_err_cnt", err_seen, 1);

    send_start(); send_bit(1'b0); send_bit(1'b1);
    send_start();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    send_stop();
    check_val("restart_data", data, 4'h6);
    check_val("restart_oh", outhigh, 16'h0040);
    check_val("restart_rdy_cnt", rdy_seen, 4);

    e0 = err_seen;
    send_start(); send_bit(1'b1); send_bit(1'b0);
    do_reset();
    send_frame(4'h9);
    check_val("post_rst_data", data, 4'h9);
    check_val("post_rst_oh", outhigh, 16'h0200);
    check_val("post_rst_no_err", err_seen, e0);

    repeat (150) begin
      case ($urandom_range(0, 5))
        0, 1: send_frame(DW'($urandom));
        2: begin
          int k = $urandom_range(1, DW - 1);
          send_start();
          for (int i = 0; i < k; i++) send_bit(1'($urandom));
          send_stop();
        end
        3: begin
          int k = $urandom_range(1, DW);
          send_start();
          for (int i = 0; i < k; i++) send_bit(1'($urandom));
          send_frame(DW'($urandom));
        end
        4: begin
          int k = $urandom_range(1, 3);
          for (int i = 0; i < k; i++) send_bit(1'($urandom));
          repeat ($urandom_range(0, 4)) @(posedge sclk);
        end
        default: begin
          if ($urandom_range(0, 3) == 0) begin
            send_start(); send_bit(1'($urandom));
            do_reset();
          end
        end
      endcase
    end

    repeat (4) @(posedge sclk);
    #1;
    check_val("total_rdy", rdy_seen, commits);
    check_val("total_err", err_seen, errs);
    check_val("rdy_err_overlap", both_seen, 0);
    check_val("final_data", data, exp_data);
    check_val("final_outhigh", outhigh, exp_oh);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sda_to_par.md
SDA_TO_PAR -- requirements
Module: sda_to_par

Interface
REQ-001 Parameter: DW, 4, payload bits per frame.
REQ-002 Parameter: OW, 16 (=2**DW), width of one-hot decode output.
REQ-003 sclk  input  1  system clock; all logic on posedge sclk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 scl  input  1  serial clock from upstream parallel-to-serial transmitter, same sclk domain.
REQ-006 sda  input  1  serial data from upstream transmitter.
REQ-007 data  output  DW  last correctly framed payload, MSB first on the wire.
REQ-008 outhigh  output  OW  one-hot decode of data: bit[data] = 1, others 0.
REQ-009 rdy  output  1  one-cycle pulse: new frame committed to data/outhigh.
REQ-010 frm_err  output  1  one-cycle pulse: frame aborted by premature stop.

Function
REQ-011 Inputs registered each posedge into scl_q/sda_q; previous samples held in scl_d/sda_d; all detection uses these four registers only.
REQ-012 Start condition: scl_d=1, scl_q=1, sda_d=1, sda_q=0.
REQ-013 Stop condition: scl_d=1, scl_q=1, sda_d=0, sda_q=1.
REQ-014 Bit strobe: scl_d=0, scl_q=1 (scl rising); sampled bit value = sda_q.
REQ-015 States: IDLE, BIT (counter DW-1 down to 0), WAIT_STOP.
REQ-016 IDLE: start -> BIT, bit counter = DW-1, shift register cleared; all else ignored.
REQ-017 BIT: on bit strobe, shift sda_q into shift register LSB side; counter 0 -> WAIT_STOP, else decrement.
REQ-018 WAIT_STOP: stop -> commit shift register to data, outhigh = 1<<data, rdy pulse, -> IDLE; bit strobes ignored.
REQ-019 Commit latency: data, outhigh, rdy all update at posedge immediately after the posedge at which stop condition first appears in the sample registers.
REQ-020 rdy and frm_err high for exactly one sclk cycle per event; never both high.
REQ-021 Start seen in BIT or WAIT_STOP: discard partial frame, restart BIT with counter DW-1; no rdy, no frm_err.
REQ-022 Stop seen in BIT (fewer than DW bits received): frm_err pulse, -> IDLE; data/outhigh unchanged.
REQ-023 Start/stop and bit strobe cannot coincide (scl must be high on both samples); start/stop has priority over everything.
REQ-024 data and outhigh hold last committed value indefinitely between frames; back-to-back frames (stop followed directly by start) each commit.
REQ-025 Frame with payload 0 commits normally: data=0, outhigh=16'h0001.

Reset
REQ-026 rst low: state IDLE, counter 0, shift register 0, data 0, outhigh 0, rdy 0, frm_err 0.
REQ-027 rst low: scl_q, scl_d, sda_q, sda_d reset to 1 (idle bus) so release of reset never yields spurious start/stop.
REQ-028 rst asserted mid-frame: frame lost; after release, first start begins a fresh frame.

Verification
REQ-029 Reset, bus idle high 20 cycles -> outputs all 0, rdy/frm_err never pulse.
REQ-030 Start, bits 1,0,1,1, stop -> data=4'hB, outhigh=16'h0800, rdy one cycle, one cycle after stop sampled.
REQ-031 Frame 4'h0 then immediately frame 4'hF -> outhigh 16'h0001 then 16'h8000, two rdy pulses.
REQ-032 Start, bits 1,1, stop -> frm_err one cycle, data/outhigh keep previous value, no rdy.
REQ-033 Start, bits 0,1, new start, bits 0,1,1,0, stop -> data=4'h6, outhigh=16'h0040, single rdy.
REQ-034 rst pulsed after 2 bits of a frame, then full frame 4'h9 -> data=4'h9, outhigh=16'h0200, no frm_err.
